io_input_port: RTL and testbench



---
 rtl/io_map_pkg.sv | 12 +
 rtl/io_input_port_debounce.sv | 51 +++++
 rtl/io_input_port.sv | 88 ++++++++
 tb/tb_io_input_port.sv | 361 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/io_map_pkg.sv
// Address map and widths shared by the input-side IO responder.
package io_map_pkg;

    localparam int IO_DATA_W   = 32;
    localparam int PRESS_CNT_W = 16;

    localparam logic [3:0] ADDR_SW   = 4'h4;
    localparam logic [3:0] ADDR_BTN  = 4'h5;
    localparam logic [3:0] ADDR_PEND = 4'h6;
    localparam logic [3:0] ADDR_CNT  = 4'h7;

endpackage

// File: rtl/io_input_port_debounce.sv
// One-bit two-flop synchronizer followed by a stable-level debouncer.
module debounce_cell #(
    parameter  int DB_CYCLES = 100000,
    localparam int DB_W      = $clog2(DB_CYCLES)
) (
    input  logic CLK,
    input  logic RESET,
    input  logic din,
    output logic dout
);

    localparam logic [DB_W-1:0] CNT_MAX = DB_W'(DB_CYCLES - 1);

    logic            sync1_q, sync1_d;
    logic            sync2_q, sync2_d;
    logic            s_q, s_d;
    logic [DB_W-1:0] cnt_q, cnt_d;

    always_comb begin
        sync1_d = din;
        sync2_d = sync1_q;
        s_d     = s_q;
        cnt_d   = cnt_q;
        // Any sample that agrees with the stable level restarts the run.
        if (sync2_q == s_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
            s_d   = sync2_q;
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            s_q     <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            s_q     <= s_d;
            cnt_q   <= cnt_d;
        end
    end

    assign dout = s_q;

endmodule

// File: rtl/io_input_port.sv
// Input-side IO responder: debounced switches/buttons, press latching and
// counting, and the read-data mux driving the processor's IOReadData.
module io_input_port
    import io_map_pkg::*;
#(
    parameter int N_SW      = 2,
    parameter int N_BTN     = 4,
    parameter int DB_CYCLES = 100000
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic [N_SW-1:0]      SWITCHES,
    input  logic [N_BTN-1:0]     BUTTONS,
    input  logic [3:0]           IOAddr,
    input  logic                 IOReadEn,
    output logic [IO_DATA_W-1:0] IOReadData,
    output logic                 IRQ
);

    logic [N_SW-1:0]        s_sw;
    logic [N_BTN-1:0]       s_btn;
    logic [N_BTN-1:0]       press_event;
    logic [N_BTN-1:0]       btn_prev_q, btn_prev_d;
    logic [N_BTN-1:0]       pend_q, pend_d;
    logic [PRESS_CNT_W-1:0] press_cnt_q, press_cnt_d;
    logic [PRESS_CNT_W-1:0] cnt_inc;

    for (genvar i = 0; i < N_SW; i++) begin : g_sw
        debounce_cell #(.DB_CYCLES(DB_CYCLES)) u_db (
            .CLK   (CLK),
            .RESET (RESET),
            .din   (SWITCHES[i]),
            .dout  (s_sw[i])
        );
    end

    for (genvar i = 0; i < N_BTN; i++) begin : g_btn
        debounce_cell #(.DB_CYCLES(DB_CYCLES)) u_db (
            .CLK   (CLK),
            .RESET (RESET),
            .din   (BUTTONS[i]),
            .dout  (s_btn[i])
        );
    end

    assign press_event = s_btn & ~btn_prev_q;

    always_comb begin
        btn_prev_d = s_btn;
        cnt_inc    = '0;
        for (int i = 0; i < N_BTN; i++) begin
            cnt_inc = cnt_inc + PRESS_CNT_W'(press_event[i]);
        end
        press_cnt_d = press_cnt_q + cnt_inc;
        // A read reports every set flag, so only presses landing this cycle survive.
        if (IOReadEn && (IOAddr == ADDR_PEND)) begin
            pend_d = press_event;
        end else begin
            pend_d = pend_q | press_event;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            btn_prev_q  <= '0;
            pend_q      <= '0;
            press_cnt_q <= '0;
        end else begin
            btn_prev_q  <= btn_prev_d;
            pend_q      <= pend_d;
            press_cnt_q <= press_cnt_d;
        end
    end

    always_comb begin
        IOReadData = '0;
        case (IOAddr)
            ADDR_SW:   IOReadData[N_SW-1:0]        = s_sw;
            ADDR_BTN:  IOReadData[N_BTN-1:0]       = s_btn;
            ADDR_PEND: IOReadData[N_BTN-1:0]       = pend_q;
            ADDR_CNT:  IOReadData[PRESS_CNT_W-1:0] = press_cnt_q;
            default:   IOReadData = '0;
        endcase
    end

    assign IRQ = |pend_q;

endmodule

// File: tb/tb_io_input_port.sv
// Directed bench: small DUT (DB_CYCLES=4) for timing/clear behaviour and a
// 16-button DB_CYCLES=2 instance to reach the press-counter wrap quickly.
`timescale 1ns/1ps
module tb_io_input_port;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic [1:0]  SWITCHES = '0;
    logic [3:0]  BUTTONS = '0;
    logic [1:0]  sw2 = '0;
    logic [15:0] btn2 = '0;
    logic [3:0]  IOAddr = '0;
    logic        IOReadEn = 1'b0;
    logic [31:0] rd1, rd2;
    logic        irq1, irq2;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 CLK = ~CLK;

    io_input_port #(.N_SW(2), .N_BTN(4), .DB_CYCLES(4)) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .SWITCHES   (SWITCHES),
        .BUTTONS    (BUTTONS),
        .IOAddr     (IOAddr),
        .IOReadEn   (IOReadEn),
        .IOReadData (rd1),
        .IRQ        (irq1)
    );

    io_input_port #(.N_SW(2), .N_BTN(16), .DB_CYCLES(2)) dut_wide (
        .CLK        (CLK),
        .RESET      (RESET),
        .SWITCHES   (sw2),
        .BUTTONS    (btn2),
        .IOAddr     (IOAddr),
        .IOReadEn   (IOReadEn),
        .IOReadData (rd2),
        .IRQ        (irq2)
    );

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic peek(input logic [3:0] a, output logic [31:0] v1, output logic [31:0] v2);
        IOAddr = a;
        #1;
        v1 = rd1;
        v2 = rd2;
    endtask

    task automatic test_reset();
        logic [31:0] v1, v2;
        RESET = 1'b1;
        tick();
        tick();
        RESET = 1'b0;
        for (int a = 4; a <= 7; a++) begin
            peek(4'(a), v1, v2);
            n_checks++;
            if (v1 !== 32'h0) begin
                n_fail++;
                $display("FAIL reset_read addr %0d: got %h expected %h", a, v1, 32'h0);
            end
        end
        n_checks++;
        if (irq1 !== 1'b0 || irq2 !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_irq: got %b/%b expected 0/0", irq1, irq2);
        end
        peek(4'h7, v1, v2);
        n_checks++;
        if (v2 !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_cnt_wide: got %h expected %h", v2, 32'h0);
        end
    endtask

    task automatic test_switches();
        logic [31:0] v1, v2, exp;
        SWITCHES = 2'b10;
        for (int k = 1; k <= 8; k++) begin
            tick();
            peek(4'h4, v1, v2);
            exp = (k >= 6) ? 32'h2 : 32'h0;
            n_checks++;
            if (v1 !== exp) begin
                n_fail++;
                $display("FAIL sw_latency clk %0d: got %h expected %h", k, v1, exp);
            end
        end
    endtask

    task automatic test_glitch();
        logic [31:0] v1, v2;
        logic [3:0]  pat;
        pat = 4'b0101;
        for (int k = 0; k < 12; k++) begin
            BUTTONS[0] = (k < 4) ? pat[k] : 1'b0;
            tick();
            peek(4'h5, v1, v2);
            n_checks++;
            if (v1 !== 32'h0 || irq1 !== 1'b0) begin
                n_fail++;
                $display("FAIL glitch_btn clk %0d: got %h irq %b expected 0 irq 0", k, v1, irq1);
            end
        end
        peek(4'h6, v1, v2);
        n_checks++;
        if (v1 !== 32'h0) begin
            n_fail++;
            $display("FAIL glitch_pend: got %h expected %h", v1, 32'h0);
        end
        peek(4'h7, v1, v2);
        n_checks++;
        if (v1 !== 32'h0) begin
            n_fail++;
            $display("FAIL glitch_cnt: got %h expected %h", v1, 32'h0);
        end
    endtask

    task automatic test_press();
        logic [31:0] v1, v2;
        BUTTONS = 4'b0101;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (k == 8) begin
                peek(4'h5, v1, v2);
                n_checks++;
                if (v1 !== 32'h5) begin
                    n_fail++;
                    $display("FAIL press_level: got %h expected %h", v1, 32'h5);
                end
            end
        end
        BUTTONS = 4'b0000;
        repeat (6) tick();
        peek(4'h6, v1, v2);
        n_checks++;
        if (v1 !== 32'h5 || irq1 !== 1'b1) begin
            n_fail++;
            $display("FAIL press_pend: got %h irq %b expected %h irq 1", v1, irq1, 32'h5);
        end
        peek(4'h7, v1, v2);
        n_checks++;
        if (v1 !== 32'h2) begin
            n_fail++;
            $display("FAIL press_cnt: got %h expected %h", v1, 32'h2);
        end
        peek(4'h5, v1, v2);
        n_checks++;
        if (v1 !== 32'h0) begin
            n_fail++;
            $display("FAIL release_level: got %h expected %h", v1, 32'h0);
        end
    endtask

    task automatic test_clear();
        logic [31:0] v1, v2;
        IOAddr = 4'h7;
        IOReadEn = 1'b1;
        tick();
        IOReadEn = 1'b0;
        peek(4'h6, v1, v2);
        n_checks++;
        if (v1 !== 32'h5) begin
            n_fail++;
            $display("FAIL other_addr_read_kept_pend: got %h expected %h", v1, 32'h5);
        end
        IOAddr = 4'h6;
        IOReadEn = 1'b1;
        tick();
        IOReadEn = 1'b0;
        peek(4'h6, v1, v2);
        n_checks++;
        if (v1 !== 32'h0 || irq1 !== 1'b0) begin
            n_fail++;
            $display("FAIL clear_pend: got %h irq %b expected 0 irq 0", v1, irq1);
        end
        peek(4'h7, v1, v2);
        n_checks++;
        if (v1 !== 32'h2) begin
            n_fail++;
            $display("FAIL clear_keeps_cnt: got %h expected %h", v1, 32'h2);
        end
        BUTTONS = 4'b0001;
        repeat (8) tick();
        BUTTONS = 4'b0000;
        repeat (8) tick();
        peek(4'h6, v1, v2);
        n_checks++;
        if (v1 !== 32'h1) begin
            n_fail++;
            $display("FAIL pend_btn0: got %h expected %h", v1, 32'h1);
        end
        BUTTONS = 4'b0100;
        repeat (6) tick();
        peek(4'h5, v1, v2);
        n_checks++;
        if (v1 !== 32'h4) begin
            n_fail++;
            $display("FAIL btn2_level: got %h expected %h", v1, 32'h4);
        end
        peek(4'h6, v1, v2);
        n_checks++;
        if (v1 !== 32'h1) begin
            n_fail++;
            $display("FAIL pend_before_edge: got %h expected %h", v1, 32'h1);
        end
        IOAddr = 4'h6;
        IOReadEn = 1'b1;
        tick();
        IOReadEn = 1'b0;
        peek(4'h6, v1, v2);
        n_checks++;
        if (v1 !== 32'h4 || irq1 !== 1'b1) begin
            n_fail++;
            $display("FAIL clear_with_press: got %h irq %b expected %h irq 1", v1, irq1, 32'h4);
        end
        peek(4'h7, v1, v2);
        n_checks++;
        if (v1 !== 32'h4) begin
            n_fail++;
            $display("FAIL cnt_after_clear: got %h expected %h", v1, 32'h4);
        end
        BUTTONS = 4'b0000;
        repeat (8) tick();
    endtask

    task automatic test_reset_mid();
        logic [31:0] v1, v2;
        BUTTONS = 4'b0010;
        repeat (4) tick();
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        peek(4'h5, v1, v2);
        n_checks++;
        if (v1 !== 32'h0) begin
            n_fail++;
            $display("FAIL rst_level: got %h expected %h", v1, 32'h0);
        end
        peek(4'h6, v1, v2);
        n_checks++;
        if (v1 !== 32'h0 || irq1 !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_pend: got %h irq %b expected 0 irq 0", v1, irq1);
        end
        peek(4'h7, v1, v2);
        n_checks++;
        if (v1 !== 32'h0) begin
            n_fail++;
            $display("FAIL rst_cnt: got %h expected %h", v1, 32'h0);
        end
        repeat (5) tick();
        peek(4'h5, v1, v2);
        n_checks++;
        if (v1 !== 32'h0) begin
            n_fail++;
            $display("FAIL rst_level_early: got %h expected %h", v1, 32'h0);
        end
        tick();
        peek(4'h5, v1, v2);
        n_checks++;
        if (v1 !== 32'h2) begin
            n_fail++;
            $display("FAIL rst_level_back: got %h expected %h", v1, 32'h2);
        end
        tick();
        peek(4'h6, v1, v2);
        n_checks++;
        if (v1 !== 32'h2 || irq1 !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_pend_back: got %h irq %b expected %h irq 1", v1, irq1, 32'h2);
        end
        peek(4'h7, v1, v2);
        n_checks++;
        if (v1 !== 32'h1) begin
            n_fail++;
            $display("FAIL rst_cnt_back: got %h expected %h", v1, 32'h1);
        end
        BUTTONS = 4'b0000;
        repeat (8) tick();
    endtask

    task automatic pulse_wide(input logic [15:0] pat);
        btn2 = pat;
        repeat (2) tick();
        btn2 = '0;
        repeat (2) tick();
    endtask

    task automatic test_wrap();
        logic [31:0] v1, v2;
        for (int k = 0; k < 4095; k++) pulse_wide(16'hFFFF);
        repeat (6) tick();
        peek(4'h7, v1, v2);
        n_checks++;
        if (v2 !== 32'h0000_FFF0) begin
            n_fail++;
            $display("FAIL wide_cnt_multi: got %h expected %h", v2, 32'h0000_FFF0);
        end
        peek(4'h6, v1, v2);
        n_checks++;
        if (v2 !== 32'h0000_FFFF || irq2 !== 1'b1) begin
            n_fail++;
            $display("FAIL wide_pend_all: got %h irq %b expected %h irq 1", v2, irq2, 32'h0000_FFFF);
        end
        pulse_wide(16'h7FFF);
        repeat (6) tick();
        peek(4'h7, v1, v2);
        n_checks++;
        if (v2 !== 32'h0000_FFFF) begin
            n_fail++;
            $display("FAIL wide_cnt_max: got %h expected %h", v2, 32'h0000_FFFF);
        end
        pulse_wide(16'h0001);
        repeat (6) tick();
        peek(4'h7, v1, v2);
        n_checks++;
        if (v2 !== 32'h0000_0000) begin
            n_fail++;
            $display("FAIL wide_cnt_wrap: got %h expected %h", v2, 32'h0);
        end
        peek(4'h3, v1, v2);
        n_checks++;
        if (v1 !== 32'h0 || v2 !== 32'h0) begin
            n_fail++;
            $display("FAIL unmapped_addr3: got %h/%h expected 0/0", v1, v2);
        end
        peek(4'hF, v1, v2);
        n_checks++;
        if (v1 !== 32'h0) begin
            n_fail++;
            $display("FAIL unmapped_addrF: got %h expected %h", v1, 32'h0);
        end
        peek(4'h4, v1, v2);
        n_checks++;
        if (v1 !== 32'h2) begin
            n_fail++;
            $display("FAIL sw_after_all: got %h expected %h", v1, 32'h2);
        end
    endtask

    initial begin
        test_reset();
        test_switches();
        test_glitch();
        test_press();
        test_clear();
        test_reset_mid();
        test_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
